// File: rtl/async_sync_filter.sv
// async_sync_filter: per-channel metastability chain, stability filter and
// edge detector for asynchronous single-bit inputs, with sticky
// write-1-to-clear event flags and a combined interrupt.
module async_sync_filter #(
    parameter int             NCH           = 8,
    parameter int             SYNC_STAGES   = 2,
    parameter int             FILTER_CYCLES = 4,
    parameter logic [NCH-1:0] RESET_VAL     = '0,
    parameter logic [NCH-1:0] EV_RISE       = '1,
    parameter logic [NCH-1:0] EV_FALL       = '0
) (
    input  logic           clk,
    input  logic           rstn,
    input  logic [NCH-1:0] d,
    output logic [NCH-1:0] q,
    output logic [NCH-1:0] rise,
    output logic [NCH-1:0] fall,
    output logic [NCH-1:0] events,
    input  logic [NCH-1:0] ev_clr,
    output logic           irq
);

    localparam int             CW       = $clog2(FILTER_CYCLES + 1);
    localparam logic [CW-1:0] CNT_LAST = CW'(FILTER_CYCLES - 1);

    (* ASYNC_REG = "TRUE" *) logic [NCH-1:0] sync_p [SYNC_STAGES];

    logic [NCH-1:0] s;
    logic [CW-1:0]  cnt_p1     [NCH];
    logic [CW-1:0]  cnt_nxt    [NCH];
    logic [NCH-1:0] upd;
    logic [NCH-1:0] q_p1;
    logic [NCH-1:0] rise_p1;
    logic [NCH-1:0] fall_p1;
    logic [NCH-1:0] events_p2;
    logic [NCH-1:0] ev_set;

    // ---- stage p0: synchroniser chain, s is the last flop ----
    // Shift each asynchronous input through the metastability chain.
    always_ff @(posedge clk or negedge rstn) begin
        if (!rstn) begin
            for (int i = 0; i < SYNC_STAGES; i++) begin
                sync_p[i] <= RESET_VAL;
            end
        end else begin
            sync_p[0] <= d;
            for (int i = 1; i < SYNC_STAGES; i++) begin
                sync_p[i] <= sync_p[i-1];
            end
        end
    end

    assign s = sync_p[SYNC_STAGES-1];

    // Per channel: count consecutive samples that differ from q; any agreeing
    // sample restarts the count, the last count commits the new level.
    always_comb begin
        upd = '0;
        for (int c = 0; c < NCH; c++) begin
            cnt_nxt[c] = '0;
            if (s[c] != q_p1[c]) begin
                if (cnt_p1[c] == CNT_LAST) begin
                    upd[c] = 1'b1;
                end else begin
                    cnt_nxt[c] = cnt_p1[c] + CW'(1);
                end
            end
        end
    end

    // ---- stage p1: filtered level and edge pulses ----
    // Register the filter state; edge pulses share the edge that updates q.
    always_ff @(posedge clk or negedge rstn) begin
        if (!rstn) begin
            for (int c = 0; c < NCH; c++) begin
                cnt_p1[c] <= '0;
            end
            q_p1    <= RESET_VAL;
            rise_p1 <= '0;
            fall_p1 <= '0;
        end else begin
            for (int c = 0; c < NCH; c++) begin
                cnt_p1[c] <= cnt_nxt[c];
            end
            q_p1    <= q_p1 ^ upd;
            rise_p1 <= upd & s;
            fall_p1 <= upd & ~s;
        end
    end

    assign ev_set = (rise_p1 & EV_RISE) | (fall_p1 & EV_FALL);

    // ---- stage p2: sticky event flags ----
    // Clear-then-set ordering so a set in the same cycle as a clear wins.
    always_ff @(posedge clk or negedge rstn) begin
        if (!rstn) begin
            events_p2 <= '0;
        end else begin
            events_p2 <= (events_p2 & ~ev_clr) | ev_set;
        end
    end

    assign q      = q_p1;
    assign rise   = rise_p1;
    assign fall   = fall_p1;
    assign events = events_p2;
    assign irq    = |events_p2;

endmodule

// File: tb/tb_async_sync_filter.sv
// Directed bench for async_sync_filter: reset/idle, latency, glitch
// rejection, event masks, set/clear collision and reset mid-count.
module tb_async_sync_filter;

    logic       clk;
    logic       rstn;
    logic [7:0] d;
    logic [7:0] q;
    logic [7:0] rise;
    logic [7:0] fall;
    logic [7:0] events;
    logic [7:0] ev_clr;
    logic       irq;

    int n_vec;
    int n_err;

    async_sync_filter #(
        .NCH(8),
        .SYNC_STAGES(2),
        .FILTER_CYCLES(4),
        .RESET_VAL(8'h00),
        .EV_RISE(8'h01),
        .EV_FALL(8'h02)
    ) dut (
        .clk(clk),
        .rstn(rstn),
        .d(d),
        .q(q),
        .rise(rise),
        .fall(fall),
        .events(events),
        .ev_clr(ev_clr),
        .irq(irq)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    task automatic chk(input string tag, input logic [7:0] obs, input logic [7:0] exp);
        n_vec++;
        assert (obs === exp) else begin
            n_err++;
            $error("FAIL %s: observed %h expected %h", tag, obs, exp);
        end
    endtask

    // advance one edge and settle away from it
    task automatic tick();
        @(posedge clk);
        #1;
    endtask

    initial begin
        n_vec  = 0;
        n_err  = 0;
        rstn   = 1'b0;
        d      = 8'h00;
        ev_clr = 8'h00;

        // reset state
        repeat (3) tick();
        chk("rst_q", q, 8'h00);
        chk("rst_rise", rise, 8'h00);
        chk("rst_fall", fall, 8'h00);
        chk("rst_events", events, 8'h00);
        chk("rst_irq", {7'b0, irq}, 8'h00);

        // idle after release with d equal to reset value
        rstn = 1'b1;
        for (int k = 0; k < 20; k++) begin
            tick();
            chk("idle_q", q, 8'h00);
            chk("idle_edges", rise | fall, 8'h00);
            chk("idle_events", events, 8'h00);
            chk("idle_irq", {7'b0, irq}, 8'h00);
        end

        // latency: d[0] 0->1, q/rise at edge 5, events/irq at edge 6
        d = 8'h01;
        for (int k = 0; k < 9; k++) begin
            tick();
            chk("lat_q0", {7'b0, q[0]}, (k >= 5) ? 8'h01 : 8'h00);
            chk("lat_rise0", {7'b0, rise[0]}, (k == 5) ? 8'h01 : 8'h00);
            chk("lat_ev0", {7'b0, events[0]}, (k >= 6) ? 8'h01 : 8'h00);
            chk("lat_irq", {7'b0, irq}, (k >= 6) ? 8'h01 : 8'h00);
        end

        // clear ch0 flag
        ev_clr = 8'h01;
        tick();
        ev_clr = 8'h00;
        chk("clr_events", events, 8'h00);
        chk("clr_irq", {7'b0, irq}, 8'h00);

        // glitch: d[1] high for 3 cycles is rejected
        d = 8'h03;
        repeat (3) tick();
        d = 8'h01;
        for (int k = 3; k < 12; k++) begin
            tick();
            chk("glitch_q1", {7'b0, q[1]}, 8'h00);
            chk("glitch_rise1", {7'b0, rise[1]}, 8'h00);
        end

        // d[1] high for 6 cycles: rise at 5, fall at 6+5=11
        d = 8'h03;
        for (int k = 0; k < 15; k++) begin
            tick();
            if (k == 5) d = 8'h01;
            chk("pw_q1", {7'b0, q[1]}, (k >= 5 && k < 11) ? 8'h01 : 8'h00);
            chk("pw_rise1", {7'b0, rise[1]}, (k == 5) ? 8'h01 : 8'h00);
            chk("pw_fall1", {7'b0, fall[1]}, (k == 11) ? 8'h01 : 8'h00);
            chk("pw_bothhi", rise & fall, 8'h00);
        end
        // ch1 rise masked off, ch1 fall sets its flag
        chk("mask_after_ch1", events, 8'h02);

        // ch0 fall is masked, then ch0 rise sets flag
        d = 8'h00;
        repeat (8) tick();
        chk("mask_ch0_fall_q", q, 8'h00);
        chk("mask_ch0_fall_ev", events, 8'h02);
        d = 8'h01;
        repeat (8) tick();
        chk("mask_ch0_rise_q", q, 8'h01);
        chk("mask_both_ev", events, 8'h03);
        chk("mask_irq", {7'b0, irq}, 8'h01);

        ev_clr = 8'h01;
        tick();
        ev_clr = 8'h00;
        chk("w1c_ch0", events, 8'h02);
        tick();
        chk("w1c_hold", events, 8'h02);
        ev_clr = 8'h02;
        tick();
        ev_clr = 8'h00;
        chk("w1c_all", events, 8'h00);
        chk("w1c_irq", {7'b0, irq}, 8'h00);

        // set/clear collision on ch0
        d = 8'h00;
        repeat (8) tick();
        chk("coll_pre_ev", events, 8'h00);
        d = 8'h01;
        for (int k = 0; k < 6; k++) begin
            tick();
        end
        chk("coll_rise0", rise, 8'h01);
        ev_clr = 8'h01;
        tick();
        ev_clr = 8'h00;
        chk("coll_ev0", events, 8'h01);
        tick();
        chk("coll_ev0_hold", events, 8'h01);
        ev_clr = 8'h01;
        tick();
        ev_clr = 8'h00;
        chk("coll_cleanup", events, 8'h00);

        // reset mid-count on ch2
        d = 8'h05;
        for (int k = 0; k < 5; k++) begin
            tick();
            chk("rmc_pre_rise2", {7'b0, rise[2]}, 8'h00);
        end
        rstn = 1'b0;
        #1;
        chk("rmc_rst_q", q, 8'h00);
        chk("rmc_rst_edges", rise | fall, 8'h00);
        chk("rmc_rst_ev", events, 8'h00);
        repeat (2) tick();
        chk("rmc_hold_rise", rise, 8'h00);
        rstn = 1'b1;
        for (int k = 0; k < 8; k++) begin
            tick();
            chk("rmc_rise", rise, (k == 5) ? 8'h05 : 8'h00);
            chk("rmc_q", q, (k >= 5) ? 8'h05 : 8'h00);
        end
        chk("rmc_events", events, 8'h01);
        chk("rmc_irq", {7'b0, irq}, 8'h01);

        $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_err);
        $finish;
    end

endmodule
